pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DEPTH, default 1, number of cascaded register stages, legal range 1..4.
REQ-002 Parameter DATA_W, default 32, width of data payload field.
REQ-003 Parameter EXTRA_W, default 8, width of side-band field (exception code, delay-slot flag), minimum 1.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold every stage this cycle.
REQ-007 flush  input  1  replace every stage with a bubble this cycle.
REQ-008 flush_pc  input  32  PC carried by bubbles written on flush.
REQ-009 in_valid  input  1  upstream slot holds a real instruction.
REQ-010 in_pc / in_instr  input  32 / 32  upstream PC and instruction word.
REQ-011 in_data  input  DATA_W  upstream data payload.
REQ-012 in_wreg  input  5  upstream destination register number.
REQ-013 in_extra  input  EXTRA_W  upstream side-band bits.
REQ-014 out_valid, out_pc, out_instr, out_data, out_wreg, out_extra  output  1, 32, 32, DATA_W, 5, EXTRA_W  contents of last stage (DEPTH-1).
REQ-015 occupancy  output  clog2(DEPTH+1)  count of stages whose valid bit is 1.

Function
REQ-016 Per-cycle priority SHALL be reset > flush > stall > advance.
REQ-017 Advance (no reset, flush, stall): stage[0] SHALL load inputs; stage[i] SHALL load stage[i-1] for i=1..DEPTH-1; latency in->out exactly DEPTH cycles.
REQ-018 On advance with in_valid=0, stage[0] SHALL load a bubble: valid=0, pc=in_pc, instr=NOP (0x0000_0000), data=0, wreg=0, extra=0.
REQ-019 On advance with in_valid=1 and in_wreg≠0, all fields SHALL load unmodified; in_wreg=0 passes through unchanged.
REQ-020 On stall, every stage SHALL retain its contents; occupancy unchanged.
REQ-021 On flush, every stage SHALL become a bubble with pc=flush_pc; occupancy becomes 0 next cycle, regardless of stall.
REQ-022 Outputs SHALL be driven directly from last-stage registers, no combinational path from any input.
REQ-023 occupancy SHALL be a registered counter updated in the same cycle as the stages: advance adds in_valid and subtracts the valid bit shifted out of stage[DEPTH-1]; never exceeds DEPTH nor underflows.
REQ-024 A bubble SHALL never assert out_valid; downstream write-enable derives from out_valid and out_wreg≠0.

Reset
REQ-025 On reset, every stage SHALL become: valid=0, pc=PC_RESET (0x0000_3000), instr=NOP, data=0, wreg=0, extra=0; occupancy=0.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight entries within the same edge, overriding concurrent flush and stall.

Structure
REQ-027 PC_RESET, NOP encoding, register-zero constant, and exception-code widths SHALL live in the shared macros header.
REQ-028 One sub-module pipe_stage_cell (one stage: load/hold/bubble/reset) SHALL be instantiated DEPTH times by a generate loop; occupancy counter lives in the top.

Verification
REQ-029 DEPTH=1: reset, then in_valid=1, in_pc=0x3004, in_instr=0x2408_0001, in_wreg=8 for one cycle -> next cycle out_pc=0x3004, out_wreg=8, out_valid=1, occupancy=1.
REQ-030 DEPTH=3: stream PCs 0x3000,0x3004,0x3008 valid -> 0x3000 at output on 3rd edge after launch, occupancy 1,2,3 on successive edges.
REQ-031 DEPTH=3 full, stall=1 for 2 cycles -> outputs and occupancy=3 frozen; release -> stream resumes in order, nothing lost or duplicated.
REQ-032 flush=1 and stall=1 same cycle, flush_pc=0x4180 -> all stages bubble, out_pc=0x4180, out_instr=0, out_valid=0, occupancy=0.
REQ-033 in_valid=0 with in_pc=0x3010 on advance (DEPTH=1) -> out_valid=0, out_pc=0x3010, out_wreg=0, out_data=0.
REQ-034 reset=1 together with flush=1 while occupancy=2 -> out_pc=0x3000, out_valid=0, occupancy=0 after the edge.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants, stage-operation encoding and the per-cycle priority decode.
package pipe_stage_reg_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam int          EXC_CODE_W = 7;
  localparam int          DSLOT_W    = 1;
  localparam int          EXTRA_W_DEFAULT = EXC_CODE_W + DSLOT_W;

  typedef enum logic [1:0] {
    CELL_RESET  = 2'd0,
    CELL_BUBBLE = 2'd1,
    CELL_HOLD   = 2'd2,
    CELL_LOAD   = 2'd3
  } cell_op_e;

  function automatic cell_op_e cell_op(input logic reset, input logic flush, input logic stall);
    cell_op_e op;
    if (reset) begin
      op = CELL_RESET;
    end else if (flush) begin
      op = CELL_BUBBLE;
    end else if (stall) begin
      op = CELL_HOLD;
    end else begin
      op = CELL_LOAD;
    end
    return op;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline register stage: reset, bubble, hold or load, all fields registered.
module pipe_stage_cell
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int EXTRA_W = EXTRA_W_DEFAULT
) (
  input  logic               clk,
  input  cell_op_e           op,
  input  logic [31:0]        bubble_pc,
  input  logic               d_valid,
  input  logic [31:0]        d_pc,
  input  logic [31:0]        d_instr,
  input  logic [DATA_W-1:0]  d_data,
  input  logic [4:0]         d_wreg,
  input  logic [EXTRA_W-1:0] d_extra,
  output logic               q_valid,
  output logic [31:0]        q_pc,
  output logic [31:0]        q_instr,
  output logic [DATA_W-1:0]  q_data,
  output logic [4:0]         q_wreg,
  output logic [EXTRA_W-1:0] q_extra
);

  logic               valid_s, valid_r;
  logic [31:0]        pc_s, pc_r;
  logic [31:0]        instr_s, instr_r;
  logic [DATA_W-1:0]  data_s, data_r;
  logic [4:0]         wreg_s, wreg_r;
  logic [EXTRA_W-1:0] extra_s, extra_r;

  // Next-state select; an empty upstream slot still carries its PC forward.
  always_comb begin
    valid_s = valid_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    data_s  = data_r;
    wreg_s  = wreg_r;
    extra_s = extra_r;
    case (op)
      CELL_RESET: begin
        valid_s = 1'b0;
        pc_s    = PC_RESET;
        instr_s = NOP;
        data_s  = {DATA_W{1'b0}};
        wreg_s  = REG_ZERO;
        extra_s = {EXTRA_W{1'b0}};
      end
      CELL_BUBBLE: begin
        valid_s = 1'b0;
        pc_s    = bubble_pc;
        instr_s = NOP;
        data_s  = {DATA_W{1'b0}};
        wreg_s  = REG_ZERO;
        extra_s = {EXTRA_W{1'b0}};
      end
      CELL_HOLD: begin
        valid_s = valid_r;
      end
      CELL_LOAD: begin
        if (d_valid) begin
          valid_s = 1'b1;
          pc_s    = d_pc;
          instr_s = d_instr;
          data_s  = d_data;
          wreg_s  = d_wreg;
          extra_s = d_extra;
        end else begin
          valid_s = 1'b0;
          pc_s    = d_pc;
          instr_s = NOP;
          data_s  = {DATA_W{1'b0}};
          wreg_s  = REG_ZERO;
          extra_s = {EXTRA_W{1'b0}};
        end
      end
      default: begin
        valid_s = valid_r;
      end
    endcase
  end

  // Stage state registers.
  always_ff @(posedge clk) begin
    valid_r <= valid_s;
    pc_r    <= pc_s;
    instr_r <= instr_s;
    data_r  <= data_s;
    wreg_r  <= wreg_s;
    extra_r <= extra_s;
  end

  assign q_valid = valid_r;
  assign q_pc    = pc_r;
  assign q_instr = instr_r;
  assign q_data  = data_r;
  assign q_wreg  = wreg_r;
  assign q_extra = extra_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register with stall/flush and a registered occupancy count.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DEPTH   = 1,
  parameter int DATA_W  = 32,
  parameter int EXTRA_W = EXTRA_W_DEFAULT,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  input  logic               in_valid,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_instr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [4:0]         in_wreg,
  input  logic [EXTRA_W-1:0] in_extra,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic [DATA_W-1:0]  out_data,
  output logic [4:0]         out_wreg,
  output logic [EXTRA_W-1:0] out_extra,
  output logic [OCC_W-1:0]   occupancy
);

  cell_op_e op_s;

  // Chain index 0 is the upstream slot; index i+1 is the output of stage i.
  logic               ch_valid_s [DEPTH+1];
  logic [31:0]        ch_pc_s    [DEPTH+1];
  logic [31:0]        ch_instr_s [DEPTH+1];
  logic [DATA_W-1:0]  ch_data_s  [DEPTH+1];
  logic [4:0]         ch_wreg_s  [DEPTH+1];
  logic [EXTRA_W-1:0] ch_extra_s [DEPTH+1];

  logic [OCC_W-1:0] occ_s, occ_r;

  assign op_s = cell_op(reset, flush, stall);

  assign ch_valid_s[0] = in_valid;
  assign ch_pc_s[0]    = in_pc;
  assign ch_instr_s[0] = in_instr;
  assign ch_data_s[0]  = in_data;
  assign ch_wreg_s[0]  = in_wreg;
  assign ch_extra_s[0] = in_extra;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage_cell #(
      .DATA_W  (DATA_W),
      .EXTRA_W (EXTRA_W)
    ) u_cell (
      .clk       (clk),
      .op        (op_s),
      .bubble_pc (flush_pc),
      .d_valid   (ch_valid_s[g]),
      .d_pc      (ch_pc_s[g]),
      .d_instr   (ch_instr_s[g]),
      .d_data    (ch_data_s[g]),
      .d_wreg    (ch_wreg_s[g]),
      .d_extra   (ch_extra_s[g]),
      .q_valid   (ch_valid_s[g+1]),
      .q_pc      (ch_pc_s[g+1]),
      .q_instr   (ch_instr_s[g+1]),
      .q_data    (ch_data_s[g+1]),
      .q_wreg    (ch_wreg_s[g+1]),
      .q_extra   (ch_extra_s[g+1])
    );
  end

  // Occupancy tracks entries entering minus the one leaving the last stage.
  always_comb begin
    occ_s = occ_r;
    case (op_s)
      CELL_RESET:  occ_s = {OCC_W{1'b0}};
      CELL_BUBBLE: occ_s = {OCC_W{1'b0}};
      CELL_HOLD:   occ_s = occ_r;
      CELL_LOAD:   occ_s = occ_r + OCC_W'(in_valid) - OCC_W'(ch_valid_s[DEPTH]);
      default:     occ_s = occ_r;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    occ_r <= occ_s;
  end

  assign occupancy = occ_r;
  assign out_valid = ch_valid_s[DEPTH];
  assign out_pc    = ch_pc_s[DEPTH];
  assign out_instr = ch_instr_s[DEPTH];
  assign out_data  = ch_data_s[DEPTH];
  assign out_wreg  = ch_wreg_s[DEPTH];
  assign out_extra = ch_extra_s[DEPTH];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: DEPTH=1 and DEPTH=3 instances share stimulus, checked against queue models.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  wreg;
    logic [7:0]  extra;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] flush_pc = 32'h0, in_pc = 32'h0, in_instr = 32'h0, in_data = 32'h0;
  logic [4:0]  in_wreg = 5'd0;
  logic [7:0]  in_extra = 8'h0;

  logic        d1_valid, d3_valid;
  logic [31:0] d1_pc, d1_instr, d1_data, d3_pc, d3_instr, d3_data;
  logic [4:0]  d1_wreg, d3_wreg;
  logic [7:0]  d1_extra, d3_extra;
  logic [0:0]  d1_occ;
  logic [1:0]  d3_occ;

  ent_t pq1[$], pq3[$], eq1[$], eq3[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0, adv = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(1), .DATA_W(32), .EXTRA_W(8)) u_d1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
    .in_wreg(in_wreg), .in_extra(in_extra),
    .out_valid(d1_valid), .out_pc(d1_pc), .out_instr(d1_instr), .out_data(d1_data),
    .out_wreg(d1_wreg), .out_extra(d1_extra), .occupancy(d1_occ));

  pipe_stage_reg #(.DEPTH(3), .DATA_W(32), .EXTRA_W(8)) u_d3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
    .in_wreg(in_wreg), .in_extra(in_extra),
    .out_valid(d3_valid), .out_pc(d3_pc), .out_instr(d3_instr), .out_data(d3_data),
    .out_wreg(d3_wreg), .out_extra(d3_extra), .occupancy(d3_occ));

  function automatic ent_t mk(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] data, input logic [4:0] wreg, input logic [7:0] extra);
    ent_t e;
    e.v = v; e.pc = pc; e.instr = instr; e.data = data; e.wreg = wreg; e.extra = extra;
    return e;
  endfunction

  function automatic int cnt(input ent_t q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i].v);
    return n;
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference model: each pipe is a fixed-length queue, newest entry at the front.
  task automatic model_step();
    ent_t b, nw;
    adv = 1'b0;
    if (reset || flush) begin
      b = reset ? mk(1'b0, 32'h0000_3000, 32'h0, 32'h0, 5'd0, 8'h0)
                : mk(1'b0, flush_pc, 32'h0, 32'h0, 5'd0, 8'h0);
      pq1.delete(); pq3.delete();
      pq1.push_back(b);
      repeat (3) pq3.push_back(b);
    end else if (!stall) begin
      nw = in_valid ? mk(1'b1, in_pc, in_instr, in_data, in_wreg, in_extra)
                    : mk(1'b0, in_pc, 32'h0, 32'h0, 5'd0, 8'h0);
      pq1.push_front(nw); void'(pq1.pop_back());
      pq3.push_front(nw); void'(pq3.pop_back());
      if (pq1[$].v) eq1.push_back(pq1[$]);
      if (pq3[$].v) eq3.push_back(pq3[$]);
      adv = 1'b1;
    end
  endtask

  task automatic drv(input logic r, input logic f, input logic s, input logic [31:0] fpc,
                     input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] data, input logic [4:0] wr, input logic [7:0] ex);
    reset = r; flush = f; stall = s; flush_pc = fpc;
    in_valid = v; in_pc = pc; in_instr = instr; in_data = data; in_wreg = wr; in_extra = ex;
    @(posedge clk);
    #2;
    model_step();
  endtask

  // Monitor: state checks every cycle, scoreboard pop whenever a valid entry emerges.
  always @(negedge clk) begin : mon
    ent_t e;
    if (mon_en) begin
      chk("d1_occ",   32'(d1_occ),   32'(cnt(pq1)));
      chk("d1_valid", 32'(d1_valid), 32'(pq1[$].v));
      chk("d1_pc",    d1_pc,         pq1[$].pc);
      chk("d3_occ",   32'(d3_occ),   32'(cnt(pq3)));
      chk("d3_valid", 32'(d3_valid), 32'(pq3[$].v));
      chk("d3_pc",    d3_pc,         pq3[$].pc);
      if (adv && d1_valid) begin
        if (eq1.size() == 0) begin
          checks++; failures++;
          $display("FAIL d1_sb_unexpected actual=pc %h required=no output", d1_pc);
        end else begin
          e = eq1.pop_front();
          chk("d1_sb_pc", d1_pc, e.pc);
          chk("d1_sb_instr", d1_instr, e.instr);
          chk("d1_sb_data", d1_data, e.data);
          chk("d1_sb_wreg", 32'(d1_wreg), 32'(e.wreg));
          chk("d1_sb_extra", 32'(d1_extra), 32'(e.extra));
        end
      end
      if (adv && d3_valid) begin
        if (eq3.size() == 0) begin
          checks++; failures++;
          $display("FAIL d3_sb_unexpected actual=pc %h required=no output", d3_pc);
        end else begin
          e = eq3.pop_front();
          chk("d3_sb_pc", d3_pc, e.pc);
          chk("d3_sb_instr", d3_instr, e.instr);
          chk("d3_sb_data", d3_data, e.data);
          chk("d3_sb_wreg", 32'(d3_wreg), 32'(e.wreg));
          chk("d3_sb_extra", 32'(d3_extra), 32'(e.extra));
        end
      end
    end
  end

  initial begin
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    mon_en = 1'b1;
    chk("rst_d1_pc", d1_pc, 32'h0000_3000);
    chk("rst_d3_pc", d3_pc, 32'h0000_3000);
    chk("rst_d3_instr", d3_instr, 32'h0);
    chk("rst_d1_valid", 32'(d1_valid), 32'h0);
    chk("rst_d3_occ", 32'(d3_occ), 32'h0);

    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3004, 32'h2408_0001, 32'h11, 5'd8, 8'h05);
    chk("one_pc", d1_pc, 32'h3004);
    chk("one_wreg", 32'(d1_wreg), 32'd8);
    chk("one_valid", 32'(d1_valid), 32'd1);
    chk("one_occ", 32'(d1_occ), 32'd1);

    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3010, 32'hdead_beef, 32'h77, 5'd3, 8'h01);
    chk("bub_valid", 32'(d1_valid), 32'd0);
    chk("bub_pc", d1_pc, 32'h3010);
    chk("bub_wreg", 32'(d1_wreg), 32'd0);
    chk("bub_data", d1_data, 32'h0);

    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 32'(i), 5'd9, 8'h0);
      chk("stream_occ", 32'(d3_occ), 32'(i + 1));
    end
    chk("stream_pc", d3_pc, 32'h3000);
    for (int i = 0; i < 2; i++) begin
      drv(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h3ffc, 32'h0, 32'h0, 5'd1, 8'h0);
      chk("stall_pc", d3_pc, 32'h3000);
      chk("stall_occ", 32'(d3_occ), 32'd3);
    end
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300c, 32'h103, 32'h3, 5'd9, 8'h0);
    chk("resume_pc0", d3_pc, 32'h3004);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3010, 32'h104, 32'h4, 5'd9, 8'h0);
    chk("resume_pc1", d3_pc, 32'h3008);

    drv(1'b0, 1'b1, 1'b1, 32'h4180, 1'b1, 32'h3014, 32'h105, 32'h5, 5'd9, 8'h0);
    chk("flush_pc", d3_pc, 32'h4180);
    chk("flush_instr", d3_instr, 32'h0);
    chk("flush_valid", 32'(d3_valid), 32'd0);
    chk("flush_occ", 32'(d3_occ), 32'd0);

    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3020, 32'h106, 32'h6, 5'd2, 8'h0);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3024, 32'h107, 32'h7, 5'd2, 8'h0);
    chk("pre_rst_occ", 32'(d3_occ), 32'd2);
    drv(1'b1, 1'b1, 1'b0, 32'h4180, 1'b1, 32'h3028, 32'h108, 32'h8, 5'd2, 8'h0);
    chk("rstflush_pc", d3_pc, 32'h3000);
    chk("rstflush_valid", 32'(d3_valid), 32'd0);
    chk("rstflush_occ", 32'(d3_occ), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(99) == 0, $urandom_range(29) == 0, $urandom_range(3) == 0, $urandom,
          $urandom_range(2) != 0, $urandom, $urandom, $urandom, 5'($urandom), 8'($urandom));
    end
    for (int n = 0; n < 6; n++) begin
      drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h5000, 32'h0, 32'h0, 5'd0, 8'h0);
    end
    @(negedge clk);
    #1;
    chk("drain_d1", 32'(eq1.size()), 32'd0);
    chk("drain_d3", 32'(eq3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
